// File: rtl/decode7_scan.sv
// decode7_scan: time-multiplexed hex 7-segment driver with gap, blanking, leading-zero suppression and frame-synchronous update
module decode7_scan #(
  parameter int NUM_DIGITS  = 4,
  parameter int SHOW_CYCLES = 50000,
  parameter int GAP_CYCLES  = 500,
  parameter bit ACTIVE_LOW  = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [4*NUM_DIGITS-1:0] num,
  input  logic [NUM_DIGITS-1:0]   dp_en,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic                    lz_suppress,
  input  logic                    load,
  output logic [7:0]              leds,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    frame_start
);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int CMAX = SHOW_CYCLES > GAP_CYCLES ? SHOW_CYCLES : GAP_CYCLES;
  localparam int CW = CMAX > 1 ? $clog2(CMAX) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0] SHOW_LAST = CW'(SHOW_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
  localparam logic [6:0] SEG [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  typedef enum logic {SHOW, GAP} state_e;

  state_e                  state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0] stg_num_q, stg_num_d, disp_num_q, disp_num_d;
  logic [NUM_DIGITS-1:0]   stg_dp_q, stg_dp_d, disp_dp_q, disp_dp_d;
  logic                    pend_q, pend_d;
  logic [7:0]              leds_q, leds_d;
  logic [NUM_DIGITS-1:0]   sel_q, sel_d;
  logic                    fs_q, fs_d;
  logic                    show_end, adv, wrap, hi_nz, dig_dp, dig_blank, dark;
  logic [3:0]              nib;
  logic [NUM_DIGITS-1:0]   onehot;
  logic [7:0]              seg;

  always_comb begin
    show_end = state_q == SHOW && cnt_q == SHOW_LAST;
    adv = (state_q == GAP && cnt_q == GAP_LAST) || (show_end && GAP_CYCLES == 0);
    wrap = adv && idx_q == IDX_LAST;
    state_d = state_q;
    idx_d = idx_q;
    cnt_d = cnt_q + 1'b1;
    if (show_end && GAP_CYCLES != 0) begin
      state_d = GAP;
      cnt_d = '0;
    end
    if (adv) begin
      state_d = SHOW;
      cnt_d = '0;
      idx_d = idx_q == IDX_LAST ? '0 : idx_q + 1'b1;
    end
    stg_num_d = stg_num_q;
    stg_dp_d = stg_dp_q;
    disp_num_d = disp_num_q;
    disp_dp_d = disp_dp_q;
    pend_d = pend_q;
    // a load landing on the wrap cycle bypasses staging so it is never a frame late
    if (wrap) begin
      pend_d = 1'b0;
      disp_num_d = load ? num : pend_q ? stg_num_q : disp_num_q;
      disp_dp_d = load ? dp_en : pend_q ? stg_dp_q : disp_dp_q;
    end else if (load) begin
      stg_num_d = num;
      stg_dp_d = dp_en;
      pend_d = 1'b1;
    end
  end

  always_comb begin
    nib = 4'h0;
    dig_dp = 1'b0;
    dig_blank = 1'b0;
    onehot = '0;
    hi_nz = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        nib = disp_num_q[4*i +: 4];
        dig_dp = disp_dp_q[i];
        dig_blank = blank[i];
        onehot[i] = 1'b1;
      end
      if (IW'(i) >= idx_q && disp_num_q[4*i +: 4] != 4'h0) hi_nz = 1'b1;
    end
    dark = dig_blank || (lz_suppress && idx_q != '0 && !hi_nz);
    seg = dark ? 8'h00 : {dig_dp, SEG[nib]};
    leds_d = (state_q == SHOW ? seg : 8'h00) ^ {8{ACTIVE_LOW}};
    sel_d = (state_q == SHOW ? onehot : '0) ^ {NUM_DIGITS{ACTIVE_LOW}};
    fs_d = state_q == SHOW && idx_q == '0 && cnt_q == '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= SHOW;
      idx_q <= '0;
      cnt_q <= '0;
      stg_num_q <= '0;
      stg_dp_q <= '0;
      disp_num_q <= '0;
      disp_dp_q <= '0;
      pend_q <= 1'b0;
      leds_q <= {8{ACTIVE_LOW}};
      sel_q <= {NUM_DIGITS{ACTIVE_LOW}};
      fs_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      stg_num_q <= stg_num_d;
      stg_dp_q <= stg_dp_d;
      disp_num_q <= disp_num_d;
      disp_dp_q <= disp_dp_d;
      pend_q <= pend_d;
      leds_q <= leds_d;
      sel_q <= sel_d;
      fs_q <= fs_d;
    end
  end

  assign leds = leds_q;
  assign digit_sel = sel_q;
  assign frame_start = fs_q;
endmodule

// File: doc/decode7_scan.md
Name: decode7_scan

Overview:
- Parametrised successor to the single-digit hex-to-7-segment decoder.
- Drives NUM_DIGITS multiplexed common-segment displays from one clock: hex decode per digit, time-division scan with an inter-digit ghost-suppression gap, and per-digit decimal point and blanking.
- Adds leading-zero suppression and tear-free frame-synchronous update of the displayed value.
- Sits between datapath/counter logic and the board's segment and digit-enable pins.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (legal 1..8).
- SHOW_CYCLES, 50000, clk cycles each digit is driven (>=1).
- GAP_CYCLES, 500, clk cycles all outputs are off between digits (0 = no gap state).
- ACTIVE_LOW, 0, 1 inverts leds and digit_sel at the output flops.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset; one clock, reset asynchronous and active-low.
- num  input  4*NUM_DIGITS  hex value; nibble i = digit i, digit 0 least significant.
- dp_en  input  NUM_DIGITS  decimal point on per digit; sampled with num on load.
- blank  input  NUM_DIGITS  force digit dark; live, not staged.
- lz_suppress  input  1  enable leading-zero suppression; live.
- load  input  1  single-cycle strobe: stage num/dp_en for next frame.
- leds  output  8  segments: bit7 dp, bits6..0 = a,b,c,d,e,f,g.
- digit_sel  output  NUM_DIGITS  one-hot digit enable.
- frame_start  output  1  one-cycle pulse when digit 0 begins SHOW.

Behaviour:
- Segment codes (before ACTIVE_LOW): 0=7E 1=30 2=6D 3=79 4=33 5=5B 6=5F 7=70 8=7F 9=7B A=77 b=1F C=4E d=3D E=4F F=47; dp ORs 0x80.
- Registers: staged (num,dp), pending flag, display (num,dp), digit index idx, cycle counter cnt, state {SHOW, GAP}.
- Reset, async: state=SHOW, idx=0, cnt=0, staged=display=0, pending=0. leds=0, digit_sel=0 and frame_start=0 at the pin level, meaning all ones for leds/digit_sel when ACTIVE_LOW=1.
- SHOW:
  - cnt counts 0..SHOW_CYCLES-1.
  - At SHOW_CYCLES-1, go to GAP with cnt=0. If GAP_CYCLES=0, go directly to SHOW of the next digit.
- GAP:
  - cnt counts 0..GAP_CYCLES-1.
  - At the end, idx <= idx+1, wrapping NUM_DIGITS-1 -> 0; state=SHOW.
- Frame commit:
  - Occurs on the cycle idx wraps to 0.
  - If pending, display <= staged and pending <= 0.
  - If load is asserted in that same cycle, display takes this cycle's num/dp_en directly and pending=0.
- load outside a commit cycle: staged <= num/dp_en, pending <= 1. Repeated loads overwrite; the last one wins.
- Outputs are registered, one cycle latency from state/idx:
  - In SHOW: digit_sel = one-hot(idx) and leds = code(display[idx]).
  - In GAP: digit_sel = 0 and leds = 0.
- frame_start is asserted on the first output cycle of digit 0 SHOW.
- Digit dark (leds=0, digit_sel still asserted) if either:
  - blank[idx] is set, or
  - lz_suppress=1, idx!=0, and every display nibble j>=idx is 0. Dark digits also suppress dp.
- Digit 0 is never suppressed by lz_suppress, so a value of 0 displays "0".
- NUM_DIGITS=1: idx stays 0, and every SHOW entry is a frame commit plus frame_start.
- Reset mid-scan: outputs go inactive immediately (async). The first SHOW of digit 0 appears one cycle after reset_n deasserts, synchronised to clk.

Test Plan:
Bench parameters: NUM_DIGITS=4, SHOW_CYCLES=4, GAP_CYCLES=2, ACTIVE_LOW=0.
1. Reset, then load num=16'h1234 during the digit-2 SHOW -> digits still show 0000 (leds=7E) until wrap. The next frame shows digit0 leds=33, digit1=79, digit2=6D, digit3=30, each for 4 cycles separated by 2 cycles of digit_sel=0/leds=0. Frame period is 24 cycles.
2. Hex coverage: load A,b,C,d,E,F,8,9 across two frames -> leds = 77,1F,4E,3D,4F,47,7F,7B. dp_en=4'b0101 -> digits 0 and 2 have bit7 set.
3. lz_suppress=1, num=16'h0050 -> digit3 and digit2 dark, digit1=5B, digit0=7E. num=0 -> only digit0=7E lit.
4. Two loads in one frame (1111 then 2222), plus a load coincident with the wrap cycle (3333) -> the next frame shows only 3333, and pending is clear afterwards.
5. blank=4'b1000 with num=16'h8888 -> digit3 enabled with leds=00, others 7F. Toggle blank mid-frame -> takes effect on the next SHOW cycle.
6. Assert reset_n low for 1 cycle mid-GAP -> outputs 0 immediately. After release, digit0 SHOW with frame_start=1 one cycle later, and display=0. Repeat with GAP_CYCLES=0 and ACTIVE_LOW=1 -> no gap cycles, and outputs idle at all ones.
